// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ID/EX definitions for the RV32IF core.
// Holds the register index constants and the ID->EX field bundle.
package id_ex_stage_reg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int MC_LAT_DEF = 16;
  localparam int REG_IDX_W  = 5;

  localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  pc;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rs3;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN_DEF-1:0]  rs1_val;
    logic [XLEN_DEF-1:0]  rs2_val;
    logic [XLEN_DEF-1:0]  rs3_val;
    logic [XLEN_DEF-1:0]  imm;
    logic                 reg_wr_en;
    logic                 freg_wr_en;
    logic                 is_load;
    logic                 multicycle;
  } id_ex_bundle_t;

endpackage

// File: rtl/id_ex_stage_reg_mc_busy_counter.sv
// Down-counter tracking the remaining EX cycles of a multi-cycle op.
// Busy while non-zero; done when the live op reaches zero.
module mc_busy_counter #(
  parameter int MC_LAT = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             flush_i,
  input  logic             active_i,
  output logic             busy_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = active_i & (cnt_q == '0);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with multi-cycle stall, load-use bubble, flush.
// Optional perf counters built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int MC_LAT = MC_LAT_DEF,
  parameter int CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ID_valid,
  input  logic [XLEN-1:0]      ID_pc,
  input  logic [REG_IDX_W-1:0] ID_rs1,
  input  logic [REG_IDX_W-1:0] ID_rs2,
  input  logic [REG_IDX_W-1:0] ID_rs3,
  input  logic                 ID_rs3_en,
  input  logic [REG_IDX_W-1:0] ID_rd,
  input  logic [XLEN-1:0]      ID_rs1_val,
  input  logic [XLEN-1:0]      ID_rs2_val,
  input  logic [XLEN-1:0]      ID_rs3_val,
  input  logic [XLEN-1:0]      ID_imm,
  input  logic                 ID_reg_wr_en,
  input  logic                 ID_freg_wr_en,
  input  logic                 ID_is_load,
  input  logic                 ID_multicycle,
  input  logic                 flush,
  output logic                 EX_valid,
  output logic [XLEN-1:0]      EX_pc,
  output logic [XLEN-1:0]      EX_imm,
  output logic [REG_IDX_W-1:0] EX_rs1,
  output logic [REG_IDX_W-1:0] EX_rs2,
  output logic [REG_IDX_W-1:0] EX_rs3,
  output logic [REG_IDX_W-1:0] EX_rd,
  output logic [XLEN-1:0]      EX_rs1_val,
  output logic [XLEN-1:0]      EX_rs2_val,
  output logic [XLEN-1:0]      EX_rs3_val,
  output logic                 EX_reg_wr_en,
  output logic                 EX_freg_wr_en,
  output logic                 EX_is_load,
  output logic                 EX_mc_done,
  output logic                 ID_stall,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_bubble_cnt
);

  id_ex_bundle_t id_b;
  id_ex_bundle_t ex_q;
  id_ex_bundle_t ex_d;
  logic          valid_q;
  logic          valid_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             mc_busy;
  logic             mc_stall;
  logic             lu_haz;
  logic             rd_hit;
  logic             bubble;

  always_comb begin
    id_b            = '0;
    id_b.pc         = ID_pc;
    id_b.rs1        = ID_rs1;
    id_b.rs2        = ID_rs2;
    id_b.rs3        = ID_rs3;
    id_b.rd         = ID_rd;
    id_b.rs1_val    = ID_rs1_val;
    id_b.rs2_val    = ID_rs2_val;
    id_b.rs3_val    = ID_rs3_val;
    id_b.imm        = ID_imm;
    id_b.reg_wr_en  = ID_reg_wr_en;
    id_b.freg_wr_en = ID_freg_wr_en;
    id_b.is_load    = ID_is_load;
    id_b.multicycle = ID_multicycle;
  end

  mc_busy_counter #(
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) u_mc_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .flush_i    (flush),
    .active_i   (valid_q & ex_q.multicycle),
    .busy_o     (mc_busy),
    .done_o     (EX_mc_done)
  );

  assign mc_stall = valid_q & mc_busy;

  // f0 is a real FP register, so only the integer path exempts index 0
  assign rd_hit =
    (ex_q.reg_wr_en & (ex_q.rd != X0) &
     ((ex_q.rd == ID_rs1) | (ex_q.rd == ID_rs2))) |
    (ex_q.freg_wr_en &
     ((ex_q.rd == ID_rs1) | (ex_q.rd == ID_rs2) |
      (ID_rs3_en & (ex_q.rd == ID_rs3))));

  assign lu_haz   = valid_q & ex_q.is_load & ID_valid & rd_hit;
  assign ID_stall = ~flush & (mc_stall | lu_haz);
  assign bubble   = ~flush & ~mc_stall & lu_haz;

  always_comb begin
    ex_d     = ex_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (flush) begin
      valid_d         = 1'b0;
      ex_d.reg_wr_en  = 1'b0;
      ex_d.freg_wr_en = 1'b0;
      ex_d.multicycle = 1'b0;
    end else if (mc_stall) begin
      ex_d = ex_q;
    end else if (lu_haz) begin
      valid_d         = 1'b0;
      ex_d.reg_wr_en  = 1'b0;
      ex_d.freg_wr_en = 1'b0;
      ex_d.multicycle = 1'b0;
    end else begin
      ex_d     = id_b;
      valid_d  = ID_valid;
      cnt_load = 1'b1;
      if (ID_valid & ID_multicycle) begin
        cnt_val = CNT_W'(MC_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
    end
  end

  assign EX_valid      = valid_q;
  assign EX_pc         = ex_q.pc;
  assign EX_imm        = ex_q.imm;
  assign EX_rs1        = ex_q.rs1;
  assign EX_rs2        = ex_q.rs2;
  assign EX_rs3        = ex_q.rs3;
  assign EX_rd         = ex_q.rd;
  assign EX_rs1_val    = ex_q.rs1_val;
  assign EX_rs2_val    = ex_q.rs2_val;
  assign EX_rs3_val    = ex_q.rs3_val;
  assign EX_reg_wr_en  = ex_q.reg_wr_en & valid_q;
  assign EX_freg_wr_en = ex_q.freg_wr_en & valid_q;
  assign EX_is_load    = ex_q.is_load;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ID_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble   = bubble;
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg (MC_LAT=16).
// Perf expectations follow ID_EX_PERF_CNT_EN.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ID_valid = 1'b0;
  logic [31:0] ID_pc = '0;
  logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, ID_rs3 = '0, ID_rd = '0;
  logic        ID_rs3_en = 1'b0;
  logic [31:0] ID_rs1_val = '0, ID_rs2_val = '0, ID_rs3_val = '0;
  logic [31:0] ID_imm = '0;
  logic        ID_reg_wr_en = 1'b0, ID_freg_wr_en = 1'b0;
  logic        ID_is_load = 1'b0, ID_multicycle = 1'b0;
  logic        flush = 1'b0;

  logic        EX_valid;
  logic [31:0] EX_pc, EX_imm;
  logic [4:0]  EX_rs1, EX_rs2, EX_rs3, EX_rd;
  logic [31:0] EX_rs1_val, EX_rs2_val, EX_rs3_val;
  logic        EX_reg_wr_en, EX_freg_wr_en, EX_is_load;
  logic        EX_mc_done, ID_stall;
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;

  int errors = 0;
  int checks = 0;
  logic seen;

  id_ex_stage_reg dut (
    .clk             (clk),
    .rst             (rst),
    .ID_valid        (ID_valid),
    .ID_pc           (ID_pc),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_rs3          (ID_rs3),
    .ID_rs3_en       (ID_rs3_en),
    .ID_rd           (ID_rd),
    .ID_rs1_val      (ID_rs1_val),
    .ID_rs2_val      (ID_rs2_val),
    .ID_rs3_val      (ID_rs3_val),
    .ID_imm          (ID_imm),
    .ID_reg_wr_en    (ID_reg_wr_en),
    .ID_freg_wr_en   (ID_freg_wr_en),
    .ID_is_load      (ID_is_load),
    .ID_multicycle   (ID_multicycle),
    .flush           (flush),
    .EX_valid        (EX_valid),
    .EX_pc           (EX_pc),
    .EX_imm          (EX_imm),
    .EX_rs1          (EX_rs1),
    .EX_rs2          (EX_rs2),
    .EX_rs3          (EX_rs3),
    .EX_rd           (EX_rd),
    .EX_rs1_val      (EX_rs1_val),
    .EX_rs2_val      (EX_rs2_val),
    .EX_rs3_val      (EX_rs3_val),
    .EX_reg_wr_en    (EX_reg_wr_en),
    .EX_freg_wr_en   (EX_freg_wr_en),
    .EX_is_load      (EX_is_load),
    .EX_mc_done      (EX_mc_done),
    .ID_stall        (ID_stall),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rs3, input logic [4:0] rd,
                       input logic rs3en, input logic wr,
                       input logic fwr, input logic ld,
                       input logic mc);
    ID_valid      = v;
    ID_pc         = pc;
    ID_rs1        = rs1;
    ID_rs2        = rs2;
    ID_rs3        = rs3;
    ID_rd         = rd;
    ID_rs3_en     = rs3en;
    ID_rs1_val    = pc + 32'd1;
    ID_rs2_val    = pc + 32'd2;
    ID_rs3_val    = pc + 32'd3;
    ID_imm        = pc + 32'd4;
    ID_reg_wr_en  = wr;
    ID_freg_wr_en = fwr;
    ID_is_load    = ld;
    ID_multicycle = mc;
  endtask

  initial begin
    #1;
    check("rst_valid", EX_valid, 0);
    check("rst_stall", ID_stall, 0);
    check("rst_done", EX_mc_done, 0);
    check("rst_pc", EX_pc, 0);
    check("rst_perf_s", perf_stall_cnt, 0);
    check("rst_perf_b", perf_bubble_cnt, 0);
    tick();
    rst = 1'b0;

    // reset in the middle of an FDIV (cnt=7)
    drive(1, 32'h100, 1, 2, 0, 4, 0, 0, 1, 0, 1);
    tick();
    check("mc0_valid", EX_valid, 1);
    check("mc0_pc", EX_pc, 32'h100);
    check("mc0_stall", ID_stall, 1);
    ID_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mc7_stall", ID_stall, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", EX_valid, 0);
    check("arst_stall", ID_stall, 0);
    check("arst_done", EX_mc_done, 0);
    check("arst_pc", EX_pc, 0);
    check("arst_fwr", EX_freg_wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h200, 3, 4, 0, 3, 0, 1, 0, 0, 0);
    tick();
    check("post_valid", EX_valid, 1);
    check("post_pc", EX_pc, 32'h200);
    check("post_rs1v", EX_rs1_val, 32'h201);
    check("post_imm", EX_imm, 32'h204);
    check("post_wr", EX_reg_wr_en, 1);
    check("post_stall", ID_stall, 0);

    // full FDIV: 15 stall cycles then done
    drive(1, 32'h300, 1, 2, 0, 2, 0, 0, 1, 0, 1);
    tick();
    drive(1, 32'h304, 1, 2, 0, 6, 0, 1, 0, 0, 0);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (!ID_stall || EX_pc != 32'h300 || EX_mc_done) seen = 1'b1;
      tick();
    end
    check("fdiv_stall_run", seen, 0);
    check("fdiv_done", EX_mc_done, 1);
    check("fdiv_nostall", ID_stall, 0);
    check("fdiv_hold_pc", EX_pc, 32'h300);
    tick();
    check("fdiv_next_pc", EX_pc, 32'h304);
    check("fdiv_next_done", EX_mc_done, 0);
    check("fdiv_next_wr", EX_reg_wr_en, 1);

    // load-use: LW x5 then ADD rs1=x5
    drive(1, 32'h400, 1, 0, 0, 5, 0, 1, 0, 1, 0);
    tick();
    drive(1, 32'h404, 5, 7, 0, 8, 0, 1, 0, 0, 0);
    #1;
    check("lu_stall", ID_stall, 1);
    tick();
    check("lu_bub_valid", EX_valid, 0);
    check("lu_bub_wr", EX_reg_wr_en, 0);
    check("lu_bub_stall", ID_stall, 0);
    tick();
    check("lu_cap_pc", EX_pc, 32'h404);
    check("lu_cap_valid", EX_valid, 1);
    check("lu_cap_rs1", EX_rs1, 5);
`ifdef ID_EX_PERF_CNT_EN
    check("perf_stall", perf_stall_cnt, 16);
    check("perf_bubble", perf_bubble_cnt, 1);
`else
    check("perf_stall", perf_stall_cnt, 0);
    check("perf_bubble", perf_bubble_cnt, 0);
`endif

    // x0 exemption on integer path
    drive(1, 32'h500, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    drive(1, 32'h504, 0, 9, 0, 10, 0, 1, 0, 0, 0);
    #1;
    check("x0_nostall", ID_stall, 0);
    tick();
    check("x0_cap_pc", EX_pc, 32'h504);

    // FLW f0 then FMA reading f0 as rs3
    drive(1, 32'h600, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(1, 32'h604, 1, 2, 0, 3, 0, 0, 1, 0, 0);
    #1;
    check("f0_rs3off", ID_stall, 0);
    ID_rs3_en = 1'b1;
    #1;
    check("f0_rs3on", ID_stall, 1);
    tick();
    check("f0_bub_valid", EX_valid, 0);
    check("f0_bub_fwr", EX_freg_wr_en, 0);
    tick();
    check("f0_cap_pc", EX_pc, 32'h604);
    check("f0_cap_rs3", EX_rs3, 0);
    check("f0_cap_rs3v", EX_rs3_val, 32'h607);

    // flush with hazard active during a multi-cycle op at cnt=3
    drive(1, 32'h700, 1, 0, 0, 5, 0, 1, 0, 1, 1);
    tick();
    drive(1, 32'h704, 5, 0, 0, 9, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick();
    check("fl_pre_stall", ID_stall, 1);
    flush = 1'b1;
    #1;
    check("fl_stall", ID_stall, 0);
    tick();
    flush = 1'b0;
    ID_valid = 1'b0;
    #1;
    check("fl_valid", EX_valid, 0);
    check("fl_wr", EX_reg_wr_en, 0);
    check("fl_cnt0", ID_stall, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (EX_mc_done) seen = 1'b1;
      tick();
    end
    check("fl_no_done", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
